// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic leaf library.
package arith_pkg;

    localparam int ARITH_HA_WIDTH_DEFAULT = 1;

    // Per-lane half-adder result pair.
    typedef struct packed {
        logic sum;
        logic carry;
    } ha_result_t;

endpackage : arith_pkg

// File: rtl/half_adder_cell.sv
// Single-bit combinational half adder: one lane of the bit-parallel half_adder.
module half_adder_cell
    import arith_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output ha_result_t res
);

    assign res.sum   = a ^ b;
    assign res.carry = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Bit-parallel half adder with a zero-latency combinational result and an
// optional one-cycle registered, valid-qualified result.
module half_adder
    import arith_pkg::*;
#(
    parameter int WIDTH   = ARITH_HA_WIDTH_DEFAULT,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid
);

    ha_result_t lane_res [WIDTH];

    // Lanes are fully independent; nothing ripples between cells.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_cell u_cell (
                .a   (a[gi]),
                .b   (b[gi]),
                .res (lane_res[gi])
            );
            assign sum[gi]   = lane_res[gi].sum;
            assign carry[gi] = lane_res[gi].carry;
        end
    endgenerate

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] sum_q_reg;
            logic [WIDTH-1:0] carry_q_reg;
            logic             out_valid_reg;

            // Data holds when in_valid is low; only the valid flag drops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q_reg     <= '0;
                    carry_q_reg   <= '0;
                    out_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= in_valid;
                    if (in_valid) begin
                        sum_q_reg   <= sum;
                        carry_q_reg <= carry;
                    end
                end
            end

            assign sum_q     = sum_q_reg;
            assign carry_q   = carry_q_reg;
            assign out_valid = out_valid_reg;
        end else begin : g_no_out_reg
            logic unused_reg_inputs;
            assign unused_reg_inputs = ^{clk, rst_n, in_valid};

            assign sum_q     = '0;
            assign carry_q   = '0;
            assign out_valid = 1'b0;
        end
    endgenerate

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: truth-table vectors, multi-cycle corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_half_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a1, b1, iv1;
    logic       s1, c1, sq1, cq1, ov1;
    logic [7:0] a8, b8;
    logic       iv8;
    logic [7:0] s8, c8, sq8, cq8;
    logic [7:0] s0, c0, sq0, cq0;
    logic       ov8, ov0;

    half_adder #(.WIDTH(1), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
        .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
    );

    half_adder #(.WIDTH(8), .OUT_REG(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
        .sum(s8), .carry(c8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
    );

    half_adder #(.WIDTH(8), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
        .sum(s0), .carry(c0), .sum_q(sq0), .carry_q(cq0), .out_valid(ov0)
    );

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    vec_t tt [4];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each lane is a 2-input integer addition; low bit is sum, high bit is carry.
    function automatic void ref_ha(input logic [7:0] x, input logic [7:0] y,
                                   output logic [7:0] s, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            int t;
            t    = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
    endfunction

    logic [7:0] es, ec, exp_sq, exp_cq;
    logic       exp_ov;

    initial begin
        tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
        a8 = '0;   b8 = '0;   iv8 = 1'b0;

        #2;
        check("rst_sum_q_w1",   {7'b0, sq1}, 8'h00);
        check("rst_carry_q_w1", {7'b0, cq1}, 8'h00);
        check("rst_valid_w1",   {7'b0, ov1}, 8'h00);
        check("rst_sum_q_w8",   sq8, 8'h00);
        check("rst_carry_q_w8", cq8, 8'h00);
        check("rst_valid_w8",   {7'b0, ov8}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        // Truth table, streamed back-to-back with in_valid held high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a1 = tt[i].a; b1 = tt[i].b; iv1 = 1'b1;
            #1;
            check("tt_sum",   {7'b0, s1}, {7'b0, tt[i].s});
            check("tt_carry", {7'b0, c1}, {7'b0, tt[i].c});
            @(posedge clk); #1;
            check("tt_sum_q",   {7'b0, sq1}, {7'b0, tt[i].s});
            check("tt_carry_q", {7'b0, cq1}, {7'b0, tt[i].c});
            check("tt_valid",   {7'b0, ov1}, 8'h01);
            $display("tt %0d: a=%b b=%b sum=%b carry=%b sum_q=%b carry_q=%b", i, a1, b1, s1, c1, sq1, cq1);
        end

        // Single-cycle capture then hold with in_valid low.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        @(posedge clk); #1;
        check("lat_carry_q", {7'b0, cq1}, 8'h01);
        check("lat_sum_q",   {7'b0, sq1}, 8'h00);
        check("lat_valid",   {7'b0, ov1}, 8'h01);
        @(negedge clk);
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        @(posedge clk); #1;
        check("hold_valid",   {7'b0, ov1}, 8'h00);
        check("hold_carry_q", {7'b0, cq1}, 8'h01);
        check("hold_sum_q",   {7'b0, sq1}, 8'h00);
        $display("latency/hold: sum_q=%b carry_q=%b out_valid=%b", sq1, cq1, ov1);

        // Asynchronous reset mid-cycle after capturing sum_q=1.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_sum_q", {7'b0, sq1}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sum_q",   {7'b0, sq1}, 8'h00);
        check("async_rst_carry_q", {7'b0, cq1}, 8'h00);
        check("async_rst_valid",   {7'b0, ov1}, 8'h00);
        a1 = 1'b1; b1 = 1'b1;
        #1;
        check("rst_comb_sum",   {7'b0, s1}, 8'h00);
        check("rst_comb_carry", {7'b0, c1}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1; iv1 = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle_valid", {7'b0, ov1}, 8'h00);
        check("post_rst_idle_sum_q", {7'b0, sq1}, 8'h00);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
        @(posedge clk); #1;
        check("first_cap_sum_q", {7'b0, sq1}, 8'h01);
        check("first_cap_valid", {7'b0, ov1}, 8'h01);
        $display("reset sequence: sum_q=%b carry_q=%b out_valid=%b", sq1, cq1, ov1);
        @(negedge clk);
        iv1 = 1'b0;

        // Eight-lane directed vector on both register configurations.
        a8 = 8'hF0; b8 = 8'hAA; iv8 = 1'b1;
        #1;
        check("w8_sum",        s8, 8'h5A);
        check("w8_carry",      c8, 8'hA0);
        check("w8_noreg_sum",  s0, 8'h5A);
        check("w8_noreg_carry", c0, 8'hA0);
        @(posedge clk); #1;
        check("w8_sum_q",        sq8, 8'h5A);
        check("w8_carry_q",      cq8, 8'hA0);
        check("w8_valid",        {7'b0, ov8}, 8'h01);
        check("w8_noreg_sum_q",  sq0, 8'h00);
        check("w8_noreg_valid",  {7'b0, ov0}, 8'h00);
        $display("w8: a=%h b=%h sum=%h carry=%h sum_q=%h carry_q=%h", a8, b8, s8, c8, sq8, cq8);

        // Randomized traffic from a clean reset.
        @(negedge clk);
        iv8 = 1'b0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_sq = '0; exp_cq = '0; exp_ov = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            iv8 = ($urandom_range(0, 3) != 0);
            #1;
            ref_ha(a8, b8, es, ec);
            check("rnd_sum",         s8, es);
            check("rnd_carry",       c8, ec);
            check("rnd_noreg_sum",   s0, es);
            check("rnd_noreg_carry", c0, ec);
            @(posedge clk);
            if (iv8) begin
                exp_sq = es;
                exp_cq = ec;
            end
            exp_ov = iv8;
            #1;
            check("rnd_sum_q",         sq8, exp_sq);
            check("rnd_carry_q",       cq8, exp_cq);
            check("rnd_valid",         {7'b0, ov8}, {7'b0, exp_ov});
            check("rnd_noreg_sum_q",   sq0, 8'h00);
            check("rnd_noreg_carry_q", cq0, 8'h00);
            check("rnd_noreg_valid",   {7'b0, ov0}, 8'h00);
            $display("rnd %0d: a=%h b=%h v=%b sum_q=%h carry_q=%h out_valid=%b",
                     n, a8, b8, iv8, sq8, cq8, ov8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_half_adder

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bit-parallel half adder: each lane i computes sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i].
- Provides a combinational result path for immediate use by glue logic.
- Provides a registered, valid-qualified result path for pipelined datapaths.
- Sits at the leaf of the arithmetic library; used as the building block for full adders and counters.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (≥1).
- OUT_REG, 1, 1 = registered path (sum_q/carry_q/out_valid) implemented; 0 = those outputs tied to 0.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a/b for capture into the registered path.
- sum  output  WIDTH  combinational per-lane sum, a XOR b.
- carry  output  WIDTH  combinational per-lane carry, a AND b.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  sum_q/carry_q hold a valid result.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n).
- Combinational path:
  - sum = a ^ b, carry = a & b, bitwise per lane.
  - Zero latency; no dependency on clk or rst_n, so it is valid even during reset.
  - Truth table per lane (a,b → sum,carry): 00→0,0; 01→1,0; 10→1,0; 11→0,1.
  - Lanes are independent; no carry propagates between lanes.
- Registered path (OUT_REG=1):
  - On rst_n low, immediately (asynchronously): sum_q=0, carry_q=0, out_valid=0.
  - On rising clk with in_valid=1: sum_q/carry_q load the combinational sum/carry of the current a,b; out_valid=1 on the next cycle. Latency is exactly 1 cycle.
  - On rising clk with in_valid=0: out_valid=0; sum_q/carry_q hold their last values.
  - Back-to-back in_valid: one result per cycle; there is no backpressure.
  - Reset asserted mid-stream clears the in-flight result. The first capture after rst_n rises occurs on the first clk edge with in_valid=1.
- OUT_REG=0: sum_q, carry_q and out_valid are constant 0 and no flops are inferred.
- No X propagation from reset state: all registered outputs are defined from reset.

Decomposition:
- Shared package arith_pkg holds the default lane width constant (ARITH_HA_WIDTH_DEFAULT = 1) and a typedef for the per-lane {sum,carry} result pair.
- One sub-module, half_adder_cell: single-bit combinational a,b → sum,carry.
- The top instantiates WIDTH cells in a generate loop and adds the output register stage.

Test Plan:
- WIDTH=1, combinational: apply (a,b) = 00, 01, 10, 11, holding each 10 time units → sum/carry = 0/0, 1/0, 1/0, 0/1.
- Reset: assert rst_n=0 mid-cycle with prior sum_q=1 → sum_q=0, carry_q=0, out_valid=0 immediately, without waiting for a clk edge; combinational outputs keep tracking a,b.
- Registered latency: a=1, b=1, in_valid=1 for one cycle → the following cycle carry_q=1, sum_q=0, out_valid=1; the next cycle out_valid=0 and values hold.
- Streaming: in_valid held high with a,b stepping through 00, 01, 10, 11 → sum_q/carry_q follow the truth table one cycle behind; out_valid stays 1.
- WIDTH=8: a=8'hF0, b=8'hAA → sum=8'h5A, carry=8'hA0; the same values appear on sum_q/carry_q one cycle after in_valid.
- OUT_REG=0: any stimulus → sum_q=0, carry_q=0, out_valid=0; combinational outputs remain correct.
